// File: rtl/axi4_lite_slv_reg_file_if.sv
// AXI4-Lite bus bundle shared by the register-file slave and whatever drives it.
// The slave uses the slv_port modport and the initiator uses the mst_port modport.
interface axi4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 5,
  parameter int DATA_BIT_WIDTH = 32
);
  logic [ADDR_BIT_WIDTH-1:0]   awaddr;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_BIT_WIDTH-1:0]   wdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [ADDR_BIT_WIDTH-1:0]   araddr;
  logic                        arvalid;
  logic                        arready;
  logic [DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport slv_port (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport mst_port (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_slv_reg_file.sv
// AXI4-Lite slave register file with per-register RW/RO access and per-register write pulses.
// Define AXI4_LITE_SLV_REG_FILE_RD_PULSE_EN to add the o_rd_pulse read-strobe output.
module axi4_lite_slv_reg_file #(
  parameter int                                 NUM_REGS       = 8,
  parameter int                                 DATA_BIT_WIDTH = 32,
  parameter int                                 ADDR_BIT_WIDTH = 5,
  parameter logic [NUM_REGS-1:0]                RO_MASK        = '0,
  parameter logic [NUM_REGS*DATA_BIT_WIDTH-1:0] RST_VALS       = '0
) (
  input  logic                               i_clk,
  input  logic                               i_sync_rst,
  axi4_lite_if.slv_port                      if_s_axi4_lite,
  output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] o_reg_vals,
  input  logic [NUM_REGS*DATA_BIT_WIDTH-1:0] i_ro_vals,
`ifdef AXI4_LITE_SLV_REG_FILE_RD_PULSE_EN
  output logic [NUM_REGS-1:0]                o_rd_pulse,
`endif
  output logic [NUM_REGS-1:0]                o_wr_pulse
);
  localparam int         ADDR_LSB     = DATA_BIT_WIDTH/32 + 1;
  localparam int         WORD_ADDR_BW = $clog2(NUM_REGS);
  localparam int         STRB_BW      = DATA_BIT_WIDTH/8;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  if (NUM_REGS < 2) begin : g_err_num_regs
    $error("NUM_REGS must be >= 2");
  end
  if (DATA_BIT_WIDTH != 32 && DATA_BIT_WIDTH != 64) begin : g_err_data_bw
    $error("DATA_BIT_WIDTH must be 32 or 64");
  end
  if (ADDR_BIT_WIDTH < ADDR_LSB + WORD_ADDR_BW) begin : g_err_addr_bw
    $error("ADDR_BIT_WIDTH too small for NUM_REGS");
  end
  if ($bits(if_s_axi4_lite.awaddr) != ADDR_BIT_WIDTH) begin : g_err_if_addr
    $error("interface ADDR_BIT_WIDTH differs from module parameter");
  end
  if ($bits(if_s_axi4_lite.wdata) != DATA_BIT_WIDTH) begin : g_err_if_data
    $error("interface DATA_BIT_WIDTH differs from module parameter");
  end

  logic                                     aw_ready_q, w_ready_q, ar_ready_q;
  logic                                     held_aw_q, held_w_q, held_aw_d, held_w_d;
  logic                                     b_valid_q, r_valid_q;
  logic [1:0]                               b_resp_q, r_resp_q;
  logic [DATA_BIT_WIDTH-1:0]                r_data_q, rd_data;
  logic [WORD_ADDR_BW-1:0]                  wr_idx_q, rd_idx;
  logic [DATA_BIT_WIDTH-1:0]                w_data_q;
  logic [STRB_BW-1:0]                       w_strb_q;
  logic                                     aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
  logic [NUM_REGS-1:0]                      wr_sel;
  logic [NUM_REGS-1:0][DATA_BIT_WIDTH-1:0]  reg_vals;
  logic                                     unused_in_bits;

  // Only the word-index bits of the addresses matter; RW slices of i_ro_vals are ignored.
  assign unused_in_bits = ^{i_ro_vals, if_s_axi4_lite.awaddr, if_s_axi4_lite.araddr};

  assign aw_hs     = if_s_axi4_lite.awvalid & aw_ready_q;
  assign w_hs      = if_s_axi4_lite.wvalid & w_ready_q;
  assign ar_hs     = if_s_axi4_lite.arvalid & ar_ready_q;
  assign commit    = held_aw_q & held_w_q & ~b_valid_q;
  assign held_aw_d = (held_aw_q | aw_hs) & ~commit;
  assign held_w_d  = (held_w_q | w_hs) & ~commit;

  always_comb begin
    wr_sel = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      wr_sel[k] = (wr_idx_q == k[WORD_ADDR_BW-1:0]) && !RO_MASK[k];
    end
    wr_ok = |wr_sel;
  end

  always_comb begin
    rd_idx  = if_s_axi4_lite.araddr[ADDR_LSB +: WORD_ADDR_BW];
    rd_data = '0;
    rd_ok   = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_idx == k[WORD_ADDR_BW-1:0]) begin
        rd_ok   = 1'b1;
        rd_data = RO_MASK[k] ? i_ro_vals[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] : reg_vals[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      held_aw_q  <= 1'b0;
      held_w_q   <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      o_wr_pulse <= '0;
    end else begin
      held_aw_q  <= held_aw_d;
      held_w_q   <= held_w_d;
      aw_ready_q <= ~held_aw_d;
      w_ready_q  <= ~held_w_d;
      o_wr_pulse <= '0;
      if (aw_hs) wr_idx_q <= if_s_axi4_lite.awaddr[ADDR_LSB +: WORD_ADDR_BW];
      if (w_hs) begin
        w_data_q <= if_s_axi4_lite.wdata;
        w_strb_q <= if_s_axi4_lite.wstrb;
      end
      if (commit) begin
        b_valid_q  <= 1'b1;
        b_resp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        o_wr_pulse <= wr_sel;
      end else if (b_valid_q && if_s_axi4_lite.bready) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  // RO registers own no storage; their o_reg_vals slices stay zero.
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    if (RO_MASK[k]) begin : g_ro
      assign reg_vals[k] = '0;
    end else begin : g_rw
      logic [DATA_BIT_WIDTH-1:0] val_q;
      always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
          val_q <= RST_VALS[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
        end else if (commit && wr_sel[k]) begin
          for (int b = 0; b < STRB_BW; b++) begin
            if (w_strb_q[b]) val_q[8*b +: 8] <= w_data_q[8*b +: 8];
          end
        end
      end
      assign reg_vals[k] = val_q;
    end
  end
  assign o_reg_vals = reg_vals;

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else if (ar_hs) begin
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b1;
      r_data_q   <= rd_data;
      r_resp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_valid_q && if_s_axi4_lite.rready) begin
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
    end else begin
      ar_ready_q <= ~r_valid_q;
    end
  end

`ifdef AXI4_LITE_SLV_REG_FILE_RD_PULSE_EN
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      o_rd_pulse <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        o_rd_pulse[k] <= ar_hs && (rd_idx == k[WORD_ADDR_BW-1:0]);
      end
    end
  end
`endif

  assign if_s_axi4_lite.awready = aw_ready_q;
  assign if_s_axi4_lite.wready  = w_ready_q;
  assign if_s_axi4_lite.bvalid  = b_valid_q;
  assign if_s_axi4_lite.bresp   = b_resp_q;
  assign if_s_axi4_lite.arready = ar_ready_q;
  assign if_s_axi4_lite.rvalid  = r_valid_q;
  assign if_s_axi4_lite.rdata   = r_data_q;
  assign if_s_axi4_lite.rresp   = r_resp_q;
endmodule

// File: tb/tb_axi4_lite_slv_reg_file.sv
// Directed self-checking bench for axi4_lite_slv_reg_file: 6 registers, reg3 read-only,
// reg2 resets to 32'hDEADBEEF, addresses 0x18/0x1C fall outside the register range.
module tb_axi4_lite_slv_reg_file;
  localparam int          NR     = 6;
  localparam logic [5:0]  RO     = 6'b001000;
  localparam logic [191:0] RSTV  = {96'h0, 32'hDEADBEEF, 64'h0};
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic         i_clk = 1'b0;
  logic         i_sync_rst = 1'b1;
  logic [191:0] o_reg_vals;
  logic [191:0] i_ro_vals;
  logic [5:0]   o_wr_pulse;
`ifdef AXI4_LITE_SLV_REG_FILE_RD_PULSE_EN
  logic [5:0]   o_rd_pulse;
`endif
  logic [31:0]  exp_reg [NR];
  int           checks = 0;
  int           errors = 0;

  axi4_lite_if #(.ADDR_BIT_WIDTH(5), .DATA_BIT_WIDTH(32)) bus ();

  axi4_lite_slv_reg_file #(
    .NUM_REGS(NR), .DATA_BIT_WIDTH(32), .ADDR_BIT_WIDTH(5), .RO_MASK(RO), .RST_VALS(RSTV)
  ) dut (
    .i_clk(i_clk),
    .i_sync_rst(i_sync_rst),
    .if_s_axi4_lite(bus.slv_port),
    .o_reg_vals(o_reg_vals),
    .i_ro_vals(i_ro_vals),
`ifdef AXI4_LITE_SLV_REG_FILE_RD_PULSE_EN
    .o_rd_pulse(o_rd_pulse),
`endif
    .o_wr_pulse(o_wr_pulse)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [191:0] exp_flat();
    logic [191:0] v;
    for (int k = 0; k < NR; k++) v[k*32 +: 32] = exp_reg[k];
    return v;
  endfunction

  function automatic void reset_model();
    for (int k = 0; k < NR; k++) exp_reg[k] = RO[k] ? 32'h0 : RSTV[k*32 +: 32];
  endfunction

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int   n;
    logic aw_hs, w_hs;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 20) begin
      aw_hs = bus.awready; w_hs = bus.wready;
      tick();
      if (aw_hs) bus.awvalid = 1'b0;
      if (w_hs) bus.wvalid = 1'b0;
      n++;
    end
    if (bus.awvalid || bus.wvalid) begin
      checks++; errors++;
      $display("FAIL write_handshake timeout addr %h", a);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    end
  endtask

  task automatic get_b(output logic [1:0] resp, output logic [5:0] pulse);
    int n;
    n = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && n < 20) begin tick(); n++; end
    if (!bus.bvalid) begin
      checks++; errors++;
      $display("FAIL b_wait timeout");
    end
    resp = bus.bresp; pulse = o_wr_pulse;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] data, output logic [1:0] resp,
                          output int lat);
    int   n;
    logic hs;
    bus.araddr = a; bus.arvalid = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 20) begin hs = bus.arready; tick(); n++; end
    bus.arvalid = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL ar_handshake timeout addr %h", a);
    end
    lat = 1;
    bus.rready = 1'b1;
    while (!bus.rvalid && lat < 20) begin tick(); lat++; end
    data = bus.rdata; resp = bus.rresp;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int lat;
    repeat (3) tick();
    checks++; if (bus.awready !== 1'b0) begin errors++; $display("FAIL rst_awready_in got %b exp 0", bus.awready); end
    checks++; if (bus.wready !== 1'b0) begin errors++; $display("FAIL rst_wready_in got %b exp 0", bus.wready); end
    checks++; if (bus.arready !== 1'b0) begin errors++; $display("FAIL rst_arready_in got %b exp 0", bus.arready); end
    i_sync_rst = 1'b0;
    tick();
    checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin errors++; $display("FAIL rst_readies got %b exp 111", {bus.awready, bus.wready, bus.arready}); end
    checks++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin errors++; $display("FAIL rst_valids got %b exp 00", {bus.bvalid, bus.rvalid}); end
    checks++; if ({bus.bresp, bus.rresp} !== 4'b0000) begin errors++; $display("FAIL rst_resps got %b exp 0000", {bus.bresp, bus.rresp}); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rdata); end
    checks++; if (o_wr_pulse !== 6'h0) begin errors++; $display("FAIL rst_wr_pulse got %b exp 0", o_wr_pulse); end
    checks++; if (o_reg_vals !== exp_flat()) begin errors++; $display("FAIL rst_reg_vals got %h exp %h", o_reg_vals, exp_flat()); end
    axi_read(5'h08, d, r, lat);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_read_reg2 got %h exp deadbeef", d); end
    checks++; if (r !== OKAY) begin errors++; $display("FAIL rst_read_resp got %b exp 00", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL rst_read_latency got %0d exp 1", lat); end
  endtask

  task automatic test_ooo_write();
    logic hs;
    bus.wdata = 32'h12345678; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
    hs = bus.wready;
    tick();
    bus.wvalid = 1'b0;
    checks++; if (hs !== 1'b1) begin errors++; $display("FAIL ooo_w_accept got %b exp 1", hs); end
    checks++; if (bus.wready !== 1'b0) begin errors++; $display("FAIL ooo_wready_held got %b exp 0", bus.wready); end
    repeat (3) tick();
    checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL ooo_no_early_b got %b exp 0", bus.bvalid); end
    bus.awaddr = 5'h04; bus.awvalid = 1'b1;
    hs = bus.awready;
    tick();
    bus.awvalid = 1'b0;
    checks++; if (hs !== 1'b1) begin errors++; $display("FAIL ooo_aw_accept got %b exp 1", hs); end
    checks++; if ({bus.bvalid, o_wr_pulse} !== 7'h0) begin errors++; $display("FAIL ooo_commit_cycle got %b exp 0", {bus.bvalid, o_wr_pulse}); end
    tick();
    exp_reg[1] = 32'h00340078;
    checks++; if ({bus.bvalid, bus.bresp} !== {1'b1, OKAY}) begin errors++; $display("FAIL ooo_bresp got %b exp 100", {bus.bvalid, bus.bresp}); end
    checks++; if (o_wr_pulse !== 6'b000010) begin errors++; $display("FAIL ooo_pulse got %b exp 000010", o_wr_pulse); end
    checks++; if (o_reg_vals !== exp_flat()) begin errors++; $display("FAIL ooo_reg_vals got %h exp %h", o_reg_vals, exp_flat()); end
    tick();
    checks++; if ({bus.bvalid, o_wr_pulse} !== 7'b1000000) begin errors++; $display("FAIL ooo_pulse_once got %b exp 1000000", {bus.bvalid, o_wr_pulse}); end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL ooo_b_release got %b exp 0", bus.bvalid); end
  endtask

  task automatic test_ro_oor();
    logic [31:0] d; logic [1:0] r; logic [5:0] p; int lat;
    axi_write(5'h0C, 32'hFFFFFFFF, 4'hF);
    get_b(r, p);
    checks++; if (r !== SLVERR) begin errors++; $display("FAIL ro_write_resp got %b exp 10", r); end
    checks++; if (p !== 6'h0) begin errors++; $display("FAIL ro_write_pulse got %b exp 0", p); end
    checks++; if (o_reg_vals !== exp_flat()) begin errors++; $display("FAIL ro_write_regs got %h exp %h", o_reg_vals, exp_flat()); end
    axi_read(5'h0C, d, r, lat);
    checks++; if ({d, r} !== {32'hA5A5A5A5, OKAY}) begin errors++; $display("FAIL ro_read got %h/%b exp a5a5a5a5/00", d, r); end
    axi_read(5'h18, d, r, lat);
    checks++; if ({d, r} !== {32'h0, SLVERR}) begin errors++; $display("FAIL oor_read got %h/%b exp 0/10", d, r); end
    axi_write(5'h18, 32'h99999999, 4'hF);
    get_b(r, p);
    checks++; if ({r, p} !== {SLVERR, 6'h0}) begin errors++; $display("FAIL oor_write got %b/%b exp 10/000000", r, p); end
    axi_write(5'h04, 32'hFFFFFFFF, 4'h0);
    get_b(r, p);
    checks++; if ({r, p} !== {OKAY, 6'b000010}) begin errors++; $display("FAIL zero_strb got %b/%b exp 00/000010", r, p); end
    checks++; if (o_reg_vals !== exp_flat()) begin errors++; $display("FAIL zero_strb_regs got %h exp %h", o_reg_vals, exp_flat()); end
    axi_read(5'h0B, d, r, lat);
    checks++; if ({d, r} !== {32'hDEADBEEF, OKAY}) begin errors++; $display("FAIL low_bits_ignored got %h/%b exp deadbeef/00", d, r); end
    axi_read(5'h04, d, r, lat);
    checks++; if ({d, r} !== {32'h00340078, OKAY}) begin errors++; $display("FAIL rw_read got %h/%b exp 00340078/00", d, r); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r; logic [5:0] p; int n;
    axi_write(5'h0C, 32'h33333333, 4'hF);
    n = 0;
    while (!bus.bvalid && n < 20) begin tick(); n++; end
    axi_write(5'h10, 32'h44444444, 4'hF);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bus.bvalid, bus.bresp, bus.awready, bus.wready, o_wr_pulse} !== {1'b1, SLVERR, 2'b00, 6'h0}
          || o_reg_vals !== exp_flat()) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got b=%b resp=%b rdy=%b%b pulse=%b regs=%h", i, bus.bvalid,
                 bus.bresp, bus.awready, bus.wready, o_wr_pulse, o_reg_vals);
      end
      tick();
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    checks++; if (bus.bvalid !== 1'b0 || o_reg_vals !== exp_flat()) begin errors++; $display("FAIL bp_after_b got b=%b regs=%h exp 0/%h", bus.bvalid, o_reg_vals, exp_flat()); end
    tick();
    exp_reg[4] = 32'h44444444;
    checks++; if ({bus.bvalid, bus.bresp, o_wr_pulse} !== {1'b1, OKAY, 6'b010000}) begin errors++; $display("FAIL bp_second_commit got %b exp 100010000", {bus.bvalid, bus.bresp, o_wr_pulse}); end
    checks++; if (o_reg_vals !== exp_flat()) begin errors++; $display("FAIL bp_second_regs got %h exp %h", o_reg_vals, exp_flat()); end
    get_b(r, p);
  endtask

  task automatic test_concurrency();
    logic [31:0] d; logic [1:0] r; int lat;
    bus.araddr = 5'h08; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.arready, bus.rvalid, bus.rdata} !== {2'b01, 32'hDEADBEEF}) begin
        errors++;
        $display("FAIL rstall cyc %0d got arready=%b rvalid=%b rdata=%h exp 0/1/deadbeef", i, bus.arready, bus.rvalid, bus.rdata);
      end
      tick();
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    checks++; if ({bus.arready, bus.rvalid} !== 2'b10) begin errors++; $display("FAIL r_release got %b exp 10", {bus.arready, bus.rvalid}); end
    bus.awaddr = 5'h00; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 5'h00; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    exp_reg[0] = 32'hCAFEF00D;
    checks++; if ({bus.rvalid, bus.rdata, bus.rresp} !== {1'b1, 32'h0, OKAY}) begin errors++; $display("FAIL same_cycle_read got %b/%h exp 1/00000000", bus.rvalid, bus.rdata); end
    checks++; if ({bus.bvalid, bus.bresp} !== {1'b1, OKAY} || o_reg_vals !== exp_flat()) begin errors++; $display("FAIL same_cycle_write got b=%b regs=%h exp 1/%h", bus.bvalid, o_reg_vals, exp_flat()); end
    bus.rready = 1'b1; bus.bready = 1'b1;
    tick();
    bus.rready = 1'b0; bus.bready = 1'b0;
    axi_read(5'h00, d, r, lat);
    checks++; if ({d, r} !== {32'hCAFEF00D, OKAY}) begin errors++; $display("FAIL reread_reg0 got %h/%b exp cafef00d/00", d, r); end
  endtask

  task automatic test_mid_reset();
    logic [1:0] r; logic [5:0] p;
    bus.awaddr = 5'h14; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.wdata = 32'h77777777; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    i_sync_rst = 1'b1;
    repeat (2) tick();
    bus.wvalid = 1'b0;
    i_sync_rst = 1'b0;
    tick();
    reset_model();
    checks++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin errors++; $display("FAIL midrst_state got %b exp 011", {bus.bvalid, bus.awready, bus.wready}); end
    checks++; if (o_reg_vals !== exp_flat()) begin errors++; $display("FAIL midrst_regs got %h exp %h", o_reg_vals, exp_flat()); end
    bus.wdata = 32'h55555555; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    repeat (3) tick();
    checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL midrst_aw_cleared got %b exp 0", bus.bvalid); end
    bus.awaddr = 5'h14; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    get_b(r, p);
    exp_reg[5] = 32'h55555555;
    checks++; if ({r, p} !== {OKAY, 6'b100000}) begin errors++; $display("FAIL midrst_write got %b/%b exp 00/100000", r, p); end
    checks++; if (o_reg_vals !== exp_flat()) begin errors++; $display("FAIL midrst_write_regs got %h exp %h", o_reg_vals, exp_flat()); end
  endtask

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    i_ro_vals = {32'hFFFF0000, 32'hFFFF0000, 32'hA5A5A5A5, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000};
    reset_model();
    test_reset();
    test_ooo_write();
    test_ro_oor();
    test_back_to_back();
    test_concurrency();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_lite_slv_reg_file.md
Name: axi4_lite_slv_reg_file

Overview:
Parametrised AXI4-Lite slave register file with NUM_REGS registers, each individually configured as read-write (RW) or read-only (RO).
- Accepts AW and W independently, in any order, with up to one outstanding write and one outstanding read.
- Exposes all register values to user logic, plus a one-cycle write pulse per register.
- RO registers return values supplied by user logic.
- Sits between the interconnect and a peripheral's control and status logic.

Parameters:
- NUM_REGS, 8: number of registers; must be >= 2.
- DATA_BIT_WIDTH, 32: register and bus width; 32 or 64, otherwise $error.
- ADDR_BIT_WIDTH, 5: AXI address width; must be >= ADDR_LSB + WORD_ADDR_BW, otherwise $error.
- RO_MASK, '0 (NUM_REGS bits): bit k = 1 makes register k read-only.
- RST_VALS, '0 (NUM_REGS*DATA_BIT_WIDTH bits): reset value of register k is at slice [k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH].

Derived values:
- ADDR_LSB = DATA_BIT_WIDTH/32 + 1.
- WORD_ADDR_BW = $clog2(NUM_REGS).

Interface parameters ADDR_BIT_WIDTH and DATA_BIT_WIDTH must equal the module parameters, otherwise $error.

Ports:
- i_clk, input, 1: clock.
- i_sync_rst, input, 1: synchronous active-high reset.
- if_s_axi4_lite, axi4_lite_if.slv_port, -: AXI4-Lite slave port.
- o_reg_vals, output, NUM_REGS*DATA_BIT_WIDTH: current contents of the RW registers; RO slices are driven 0.
- i_ro_vals, input, NUM_REGS*DATA_BIT_WIDTH: read values for RO registers; RW slices are ignored.
- o_wr_pulse, output, NUM_REGS: bit k is high for 1 cycle after a successful write to register k.

Behaviour:
Reset:
- AWREADY, WREADY and ARREADY are 0 during reset and 1 on the first cycle after release.
- BVALID = RVALID = 0; BRESP = RRESP = OKAY; RDATA = 0.
- RW registers load RST_VALS; o_wr_pulse = 0.
- Any in-flight transaction is discarded.

Write address and data capture:
- Word index = addr[ADDR_LSB +: WORD_ADDR_BW]. Address bits above the index are ignored (aliasing); bits below ADDR_LSB are ignored.
- Held-AW flag: set on the AW handshake, which latches AWADDR; AWREADY = !held-AW.
- Held-W flag: set on the W handshake, which latches WDATA and WSTRB; WREADY = !held-W.
- AW and W may handshake in the same cycle or in any order, separated by any gap.

Write commit:
- Commit happens when both flags are set and BVALID = 0. In that cycle both flags clear and BVALID rises on the next edge.
- Commit to index < NUM_REGS with RO_MASK = 0: byte lanes with WSTRB set are updated, o_wr_pulse[k] = 1 for one cycle, BRESP = OKAY.
- Commit to an RO register or to index >= NUM_REGS: no state change, no pulse, BRESP = SLVERR.
- WSTRB = 0 to an RW register: OKAY, no data change, pulse still asserted.
- BVALID holds, with BRESP stable, until BREADY.
- While BVALID is high, a new AW/W may be captured; its commit waits until the cycle after the B handshake.

Read path:
- ARREADY = !RVALID.
- AR handshake in cycle N gives RVALID = 1 in cycle N+1, with RDATA/RRESP sampled in cycle N from the current ARADDR.
- RW register k returns its register content; RO register k returns i_ro_vals slice k; index >= NUM_REGS returns RDATA = 0 with SLVERR.
- RVALID, RDATA and RRESP hold until RREADY. RVALID falls on the edge after the R handshake; ARREADY rises in the same cycle.

Concurrency:
- Read and write paths are independent.
- A read in the same cycle as a commit to the same register returns the pre-write value.

Output timing:
- All AXI outputs and o_wr_pulse are driven directly from flops; there are no combinational input-to-output paths.

Optional Feature:
Macro AXI4_LITE_SLV_REG_FILE_RD_PULSE_EN.
- Defined: adds output port o_rd_pulse (NUM_REGS bits). Bit k is high for one cycle, aligned with RVALID rising, when a read of in-range register k is accepted on AR. Out-of-range reads produce no pulse.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset scenario: NUM_REGS=8, RST_VALS reg2=32'hDEAD_BEEF; reset, then read 0x08 -> RDATA=32'hDEADBEEF, OKAY, 1 cycle after AR handshake.
- Out-of-order write: W (data 32'h1234_5678, WSTRB 4'b0101) 3 cycles before AW to 0x04 on a zeroed reg1 -> BRESP OKAY; o_wr_pulse[1] high once; o_reg_vals reg1 = 32'h0034_0078.
- RO/out-of-range: RO_MASK bit3 set, i_ro_vals reg3 = 32'hA5A5_A5A5:
  - Write 0x0C -> SLVERR, no pulse.
  - Read 0x0C -> 32'hA5A5A5A5, OKAY.
  - NUM_REGS=6: read 0x18 -> RDATA 0, SLVERR.
- Backpressure: BREADY held low 10 cycles while a second AW+W arrives -> second write captured but not committed; BVALID with first BRESP stable; second commit in the cycle after the first B handshake.
- Concurrency: RREADY low 5 cycles -> ARREADY low throughout. Same-cycle commit/read to reg0 -> read returns old value.
- Mid-transaction reset: assert reset with AW held, W pending -> after release, BVALID 0, flags clear, register unchanged.
